// File: rtl/booth_mul_seq_if.sv
// Request/response bus of booth_mul_seq; req_acc is present only when
// BOOTH_MUL_SEQ_ACC_EN is defined.
interface booth_mul_seq_if #(
    parameter int unsigned W = 32
);
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_mode;
    logic           req_signed_1;
    logic           req_signed_2;
    logic [W-1:0]   req_in_1;
    logic [W-1:0]   req_in_2;
`ifdef BOOTH_MUL_SEQ_ACC_EN
    logic           req_acc;
`endif
    logic           resp_valid;
    logic           resp_ready;
    logic [2*W-1:0] resp_result;

`ifdef BOOTH_MUL_SEQ_ACC_EN
    modport master (
        output req_valid, req_mode, req_signed_1, req_signed_2, req_in_1, req_in_2, req_acc,
        output resp_ready,
        input  req_ready, resp_valid, resp_result
    );
    modport slave (
        input  req_valid, req_mode, req_signed_1, req_signed_2, req_in_1, req_in_2, req_acc,
        input  resp_ready,
        output req_ready, resp_valid, resp_result
    );
`else
    modport master (
        output req_valid, req_mode, req_signed_1, req_signed_2, req_in_1, req_in_2,
        output resp_ready,
        input  req_ready, resp_valid, resp_result
    );
    modport slave (
        input  req_valid, req_mode, req_signed_1, req_signed_2, req_in_1, req_in_2,
        input  resp_ready,
        output req_ready, resp_valid, resp_result
    );
`endif
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth SIMD multiplier (1xW, 2xW/2, 4xW/4 lanes), DPC digits per lane per cycle.
// Define BOOTH_MUL_SEQ_ACC_EN to add req_acc: accumulate the product onto the previous result.
module booth_mul_seq #(
    parameter int unsigned W   = 32,
    parameter int unsigned DPC = 2
) (
    input  logic           clk,
    input  logic           reset,
    booth_mul_seq_if.slave bus
);
    localparam int unsigned N0 = W / (2 * DPC);
    localparam int unsigned CW = $clog2(N0);
    localparam int unsigned IW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t         state;
    logic [W-1:0]   mul_q;
    logic [W-1:0]   mcd_q;
    logic           sgn1_q;
    logic           sgn2_q;
    logic [1:0]     mode_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_last;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_init;
    logic [2*W-1:0] step_acc;
    logic [2*W-1:0] fix_acc;
    logic [2*W-1:0] step_mode [3];
    logic [2*W-1:0] fix_mode  [3];
    logic           resp_valid_q;
    logic [2*W-1:0] resp_result_q;
    logic           accept;

    assign bus.req_ready   = (state == IDLE) || ((state == DONE) && bus.resp_ready);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign accept          = bus.req_valid && bus.req_ready;

`ifdef BOOTH_MUL_SEQ_ACC_EN
    assign acc_init = bus.req_acc ? resp_result_q : '0;
`else
    assign acc_init = '0;
`endif

    // Per-mode lane datapaths; each lane is isolated to its own 2L-bit slice.
    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int unsigned L     = W >> m;
        localparam int unsigned L2    = 2 * L;
        localparam int unsigned LANES = 1 << m;

        logic [2*W-1:0] step_v;
        logic [2*W-1:0] fix_v;

        always_comb begin
            logic [L-1:0]  y;
            logic [L-1:0]  x;
            logic [L2-1:0] xe;
            logic [L2-1:0] mag;
            logic [L2-1:0] sum;
            logic [L2-1:0] corr;
            logic [W:0]    y_ext;
            logic [IW-1:0] idx;
            logic [2:0]    dig;
            logic          neg;
            step_v = '0;
            fix_v  = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                y     = mul_q[k*L +: L];
                x     = mcd_q[k*L +: L];
                xe    = {{L{sgn2_q & x[L-1]}}, x};
                y_ext = (W+1)'({y, 1'b0});
                sum   = acc_q[k*L2 +: L2];
                for (int unsigned d = 0; d < DPC; d++) begin
                    idx = IW'(2 * (32'(cnt_q) * DPC + d));
                    dig = y_ext[idx +: 3];
                    mag = '0;
                    neg = 1'b0;
                    case (dig)
                        3'b001, 3'b010: mag = xe;
                        3'b011:         mag = {xe[L2-2:0], 1'b0};
                        3'b100: begin   mag = {xe[L2-2:0], 1'b0}; neg = 1'b1; end
                        3'b101, 3'b110: begin mag = xe; neg = 1'b1; end
                        default:        mag = '0;
                    endcase
                    // Negative digit: inverted multiplicand plus a +1 at the digit LSB.
                    sum = sum + ((neg ? ~mag : mag) << idx) + (L2'(neg) << idx);
                end
                step_v[k*L2 +: L2] = sum;
                // Booth treats the multiplier as signed; an unsigned one with MSB set needs +x<<L.
                corr = (!sgn1_q && y[L-1]) ? (xe << L) : '0;
                fix_v[k*L2 +: L2] = acc_q[k*L2 +: L2] + corr;
            end
        end

        assign step_mode[m] = step_v;
        assign fix_mode[m]  = fix_v;
    end

    always_comb begin
        step_acc = step_mode[0];
        fix_acc  = fix_mode[0];
        cnt_last = CW'(N0 - 1);
        case (mode_q)
            2'd1: begin
                step_acc = step_mode[1];
                fix_acc  = fix_mode[1];
                cnt_last = CW'(N0 / 2 - 1);
            end
            2'd2: begin
                step_acc = step_mode[2];
                fix_acc  = fix_mode[2];
                cnt_last = CW'(N0 / 4 - 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            acc_q         <= '0;
            mul_q         <= '0;
            mcd_q         <= '0;
            sgn1_q        <= 1'b0;
            sgn2_q        <= 1'b0;
            mode_q        <= 2'd0;
            cnt_q         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                    // In DONE an accept implies resp_ready, so retire and restart share the edge.
                    if (accept) begin
                        mul_q  <= bus.req_in_1;
                        mcd_q  <= bus.req_in_2;
                        sgn1_q <= bus.req_signed_1;
                        sgn2_q <= bus.req_signed_2;
                        mode_q <= (bus.req_mode == 2'd3) ? 2'd0 : bus.req_mode;
                        acc_q  <= acc_init;
                        cnt_q  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == cnt_last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    acc_q         <= fix_acc;
                    resp_result_q <= fix_acc;
                    resp_valid_q  <= 1'b1;
                    state         <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomized self-checking bench for booth_mul_seq against a lane-wise arithmetic model.
// Define BOOTH_MUL_SEQ_ACC_EN to also cover the accumulate option.
module tb_booth_mul_seq;
    localparam int unsigned W   = 32;
    localparam int unsigned DPC = 2;
`ifdef BOOTH_MUL_SEQ_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [2*W-1:0] prev     = '0;

    booth_mul_seq_if #(.W(W)) bus ();

    booth_mul_seq #(.W(W), .DPC(DPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Lane-wise reference: extend each lane per its sign flag, multiply, wrap to 2L bits.
    function automatic logic [63:0] model(input logic [1:0] mode, input bit s1, input bit s2,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] base, input bit acc);
        int unsigned m;
        int unsigned l;
        logic [63:0] lm, pm, av, bv, p, r;
        m  = (mode == 2'd3) ? 0 : 32'(mode);
        l  = 32 >> m;
        lm = (64'd1 << l) - 64'd1;
        pm = (l == 32) ? '1 : ((64'd1 << (2 * l)) - 64'd1);
        r  = '0;
        for (int unsigned k = 0; k < (1 << m); k++) begin
            av = (64'(a) >> (k * l)) & lm;
            bv = (64'(b) >> (k * l)) & lm;
            if (s1 && av[l-1]) av = av | ~lm;
            if (s2 && bv[l-1]) bv = bv | ~lm;
            p = av * bv;
            if (acc) p = p + ((base >> (2 * l * k)) & pm);
            r = r | ((p & pm) << (2 * l * k));
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] mode);
        int unsigned l;
        l = 32 >> ((mode == 2'd3) ? 0 : 32'(mode));
        return int'(l / (2 * DPC)) + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8080_8080;
            3:       return 32'h7F7F_7F7F;
            default: return $urandom();
        endcase
    endfunction

    task automatic send(input logic [1:0] mode, input bit s1, input bit s2,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        bus.req_mode     = mode;
        bus.req_signed_1 = s1;
        bus.req_signed_2 = s2;
        bus.req_in_1     = a;
        bus.req_in_2     = b;
        bus.req_valid    = 1'b1;
        while (!bus.req_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.req_in_1     = $urandom();
        bus.req_in_2     = $urandom();
        bus.req_mode     = 2'($urandom_range(0, 3));
        bus.req_signed_1 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] mode, input bit s1, input bit s2,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit acc,
                          input int hold, input bit use_exp, input logic [63:0] exp_in);
        logic [63:0] exp;
        int lat;
        exp = use_exp ? exp_in : model(mode, s1, s2, a, b, prev, ACC_ON && acc);
`ifdef BOOTH_MUL_SEQ_ACC_EN
        bus.req_acc = acc;
`endif
        send(mode, s1, s2, a, b);
        wait_resp(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(mode)));
        check({tag, "_res"}, bus.resp_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, bus.resp_result, exp);
        end
        take();
        prev = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        int lat;
        bit seen;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_mode     = 2'd0;
        bus.req_signed_1 = 1'b0;
        bus.req_signed_2 = 1'b0;
        bus.req_in_1     = '0;
        bus.req_in_2     = '0;
        bus.resp_ready   = 1'b0;
`ifdef BOOTH_MUL_SEQ_ACC_EN
        bus.req_acc      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_result", bus.resp_result, 64'd0);

        run_op("s_m1x2", 2'd0, 1, 1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("u_max2", 2'd0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 64'hFFFF_FFFE_0000_0001);
        run_op("m2_lane", 2'd2, 1, 1, 32'h807F_FF02, 32'h807F_03FE, 0, 0, 1, 64'h4000_3F01_FFFD_FFFC);

        // Stall in DONE, then retire and accept on the same edge.
        exp = model(2'd0, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, prev, 0);
        send(2'd0, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_resp(lat);
        check("stall_res", bus.resp_result, exp);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(bus.resp_valid), 64'd1);
            check("stall_stable", bus.resp_result, exp);
            check("stall_req_ready", 64'(bus.req_ready), 64'd0);
        end
        prev = exp;
        exp = model(2'd2, 0, 1, 32'hF00D_1234, 32'h8001_7FFF, prev, 0);
        bus.req_mode     = 2'd2;
        bus.req_signed_1 = 1'b0;
        bus.req_signed_2 = 1'b1;
        bus.req_in_1     = 32'hF00D_1234;
        bus.req_in_2     = 32'h8001_7FFF;
        bus.req_valid    = 1'b1;
        bus.resp_ready   = 1'b1;
        #1;
        check("b2b_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_in_1   = $urandom();
        check("b2b_retired", 64'(bus.resp_valid), 64'd0);
        wait_resp(lat);
        check("b2b_lat", 64'(lat), 64'd3);
        check("b2b_res", bus.resp_result, exp);
        take();
        prev = exp;

        // Reset in the second BUSY cycle discards the operation.
        send(2'd0, 1, 1, 32'h0BAD_F00D, 32'h1357_9BDF);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("mid_rst_resp_result", bus.resp_result, 64'd0);
        prev = '0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        check("mid_rst_no_resp", 64'(seen), 64'd0);
        run_op("after_rst", 2'd0, 0, 0, 32'd3, 32'd5, 0, 0, 1, 64'd15);

`ifdef BOOTH_MUL_SEQ_ACC_EN
        run_op("acc0", 2'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 64'hFFFE_0001_FFFE_0001);
        run_op("acc1", 2'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 64'hFFFC_0002_FFFC_0002);
`endif

        for (int n = 0; n < 60; n++) begin
            run_op("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
